key_scan_array: RTL and testbench
=================================

# key_scan_array

Parametrised N-channel push-button conditioner: per-channel two-flop synchroniser, debounce filter, registered pressed level, and single-cycle press/release event pulses, with optional long-press/auto-repeat detection. Sits between the board key pins and application control logic (mode select, menu navigation), replacing per-key single-channel debouncers with one instance per key bank.

## Interface
- `KEY_NUM`, 4: number of independent key channels (1..32).
- `DEB_CYCLES`, 1_000_000: consecutive clocks a changed synchronised level must persist before it is accepted (≥2).
- `ACTIVE_LOW`, 1: 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- `LONG_CYCLES`, 50_000_000: hold time, in clocks after the accepted press, before `key_long` fires (used only with `KEY_LONGPRESS_EN`).
- `REPEAT_CYCLES`, 10_000_000: period of `key_repeat` after `key_long` (used only with `KEY_LONGPRESS_EN`).

Ports:
- `sys_clk`, in, 1: single clock; all logic on the rising edge.
- `sys_rst`, in, 1: asynchronous, active-low reset.
- `key_in`, in, KEY_NUM: raw asynchronous key pins.
- `key_status`, out, KEY_NUM: debounced level; 1 = pressed, independent of `ACTIVE_LOW`.
- `key_press`, out, KEY_NUM: one-clock pulse on accepted press.
- `key_release`, out, KEY_NUM: one-clock pulse on accepted release.
- `key_long`, out, KEY_NUM: one-clock pulse on long-press threshold.
- `key_repeat`, out, KEY_NUM: one-clock auto-repeat pulses.
- `key_any`, out, 1: OR of `key_status`.

## Operation
- Input normalisation: `raw = ACTIVE_LOW ? ~key_in : key_in`, so 1 = pressed internally.
- Sync: `s1 <= raw`; `s2 <= s1`. On reset, both flops go to 0 (released), so there is no false press after reset.
- Per channel, debounce counter `cnt`, width `$clog2(DEB_CYCLES)`:
  - `s2 == key_status`: `cnt <= 0`. Any single-cycle glitch restarts the count.
  - `s2 != key_status` and `cnt < DEB_CYCLES-1`: `cnt <= cnt+1`.
  - `s2 != key_status` and `cnt == DEB_CYCLES-1`: `key_status <= s2`, `cnt <= 0`, and pulse `key_press` (new level 1) or `key_release` (new level 0) on the same edge.
- `cnt` never exceeds `DEB_CYCLES-1`. There is no wrap.
- Channels are fully independent. Simultaneous events on several channels all produce pulses in the same cycle.
- `key_press` and `key_release` are mutually exclusive per channel per cycle.
- Reset values: all outputs 0, all counters 0, `key_status` 0.
- Reset mid-operation clears pending counts and suppresses any pulse that would have fired. A key held through reset is re-accepted as a fresh press `DEB_CYCLES+2` clocks after release of reset.

## Timing
- Latency: raw level first captured into `s1` at edge k (input stable from then on). `key_status` and the event pulse update at edge k+1+DEB_CYCLES.
- Glitch filtering: a raw pulse shorter than DEB_CYCLES clocks, as seen at `s2`, never changes `key_status`.
- Pulse width: all event outputs are exactly one clock wide and registered. There are no combinational paths from `key_in`.
- `key_any` is a combinational OR of registered `key_status`.

## Configuration
- `KEY_LONGPRESS_EN` defined:
  - A per-channel hold counter clears on `key_press` and counts while `key_status`=1.
  - `key_long` pulses when the count reaches LONG_CYCLES-1 after the press edge.
  - `key_repeat` then pulses every REPEAT_CYCLES while the key stays held. The first repeat comes REPEAT_CYCLES after `key_long`.
  - The counter saturates/reloads with no wrap.
  - Release clears the counter. No long or repeat pulse is issued in the release cycle.
- `KEY_LONGPRESS_EN` undefined: `key_long` and `key_repeat` are tied to 0, and the hold counters are not synthesised. Ports are unchanged.

## Structure
- Package `key_pkg`:
  - `function clog2_min1` for counter widths (min 1).
  - Default constants `KEY_DEB_DEFAULT`, `KEY_LONG_DEFAULT`, `KEY_REPEAT_DEFAULT`.
- Sub-module `key_chan`: one channel holding the synchroniser, debounce counter, event pulses and optional hold counter.
- Top `key_scan_array`: `generate` loop over `KEY_NUM` instances plus the `key_any` OR.

## Test plan
Bench uses KEY_NUM=4, DEB_CYCLES=4, ACTIVE_LOW=1, LONG_CYCLES=20, REPEAT_CYCLES=8.
- Reset with `key_in`=4'b1111 held for 50 clocks → all outputs 0, with no `key_press` pulse.
- `key_in[0]` driven 1→0 captured at edge k → `key_status[0]`=1 and `key_press[0]` high for exactly one clock at edge k+5. `key_any`=1.
- `key_in[1]` glitch low for 3 clocks, then high → `key_status[1]` stays 0, and no pulses occur on any channel.
- Keys 2 and 3 pressed in the same cycle, then released in the same cycle → simultaneous `key_press[3:2]`=2'b11, later simultaneous `key_release[3:2]`=2'b11, each one clock wide.
- With `KEY_LONGPRESS_EN`, key 0 held 60 clocks past the press → `key_long[0]` 20 clocks after `key_press[0]`, then `key_repeat[0]` every 8 clocks. After release, no further pulses.
- `sys_rst` asserted mid-debounce (cnt=2) on key 0 → outputs 0 immediately and asynchronously. After deassert with the key still held, `key_press[0]` arrives DEB_CYCLES+2=6 clocks later.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and helpers for the key_scan_array push-button conditioner.
package key_pkg;

  localparam int unsigned KEY_DEB_DEFAULT    = 1_000_000;
  localparam int unsigned KEY_LONG_DEFAULT   = 50_000_000;
  localparam int unsigned KEY_REPEAT_DEFAULT = 10_000_000;

  // Counter width able to hold v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: two-flop synchroniser, debounce filter, press/release pulses and,
// when KEY_LONGPRESS_EN is defined, a hold counter producing long-press/auto-repeat pulses.
module key_chan
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = KEY_DEB_DEFAULT,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned LONG_CYCLES   = KEY_LONG_DEFAULT,
  parameter int unsigned REPEAT_CYCLES = KEY_REPEAT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic status_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned DW = clog2_min1(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          raw;
  logic          s1_q, s2_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          status_q, status_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          accept;

  // Internally 1 always means pressed.
  assign raw = ACTIVE_LOW ? ~key_i : key_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      status_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign accept = (s2_q != status_q) && (cnt_q == DEB_LAST);

  // Any cycle where the synchronised level agrees with the status restarts the count.
  always_comb begin
    cnt_d     = '0;
    status_d  = status_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (accept) begin
      status_d  = s2_q;
      press_d   = s2_q;
      release_d = ~s2_q;
    end else if (s2_q != status_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign status_o  = status_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef KEY_LONGPRESS_EN
  localparam int unsigned HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW   = clog2_min1(HMAX);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          rep_phase_q, rep_phase_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= '0;
      rep_phase_q <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      rep_phase_q <= rep_phase_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  // Press edge, release edge and idle all park the counter; only a steady hold counts.
  always_comb begin
    hold_d      = hold_q;
    rep_phase_d = rep_phase_q;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    if (accept || !status_q) begin
      hold_d      = '0;
      rep_phase_d = 1'b0;
    end else if (!rep_phase_q) begin
      if (hold_q == LONG_LAST) begin
        long_d      = 1'b1;
        hold_d      = '0;
        rep_phase_d = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end else begin
      if (hold_q == REP_LAST) begin
        repeat_d = 1'b1;
        hold_d   = '0;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  assign long_o   = long_q;
  assign repeat_o = repeat_q;
`else
  assign long_o   = 1'b0;
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/key_scan_array.sv
// Bank of KEY_NUM independent debounced key channels plus an any-key-pressed flag.
// Long-press/auto-repeat outputs are live only when KEY_LONGPRESS_EN is defined.
module key_scan_array
  import key_pkg::*;
#(
  parameter int unsigned KEY_NUM       = 4,
  parameter int unsigned DEB_CYCLES    = KEY_DEB_DEFAULT,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned LONG_CYCLES   = KEY_LONG_DEFAULT,
  parameter int unsigned REPEAT_CYCLES = KEY_REPEAT_DEFAULT
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_status,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat,
  output logic               key_any
);

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_chan
    key_chan #(
      .DEB_CYCLES   (DEB_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk_i    (sys_clk),
      .rst_ni   (sys_rst),
      .key_i    (key_in[g]),
      .status_o (key_status[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .long_o   (key_long[g]),
      .repeat_o (key_repeat[g])
    );
  end

  assign key_any = |key_status;

endmodule

// File: tb/tb_key_scan_array.sv
// Randomised and directed stimulus for key_scan_array against a window-based reference model.
module tb_key_scan_array;

  localparam int KN   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  // Clock / reset
  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic [KN-1:0] key_in  = '1;
  logic [KN-1:0] key_status, key_press, key_release, key_long, key_repeat;
  logic          key_any;

  always #5 sys_clk = ~sys_clk;

  key_scan_array #(
    .KEY_NUM      (KN),
    .DEB_CYCLES   (DEB),
    .ACTIVE_LOW   (1'b1),
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_status (key_status),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat),
    .key_any    (key_any)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: status flips once the last DEB synchronised samples all disagree with it.
  logic [KN-1:0] raw_q[$];
  logic [KN-1:0] seen_q[$];
  logic [KN-1:0] m_status;
  logic [KN-1:0] e_press, e_rel, e_long, e_rep;
  int            press_edge[KN];
  int            edge_n = 0;

  task automatic model_reset();
    raw_q.delete();
    raw_q.push_back('0);
    raw_q.push_back('0);
    seen_q.delete();
    m_status = '0;
    for (int c = 0; c < KN; c++) press_edge[c] = 0;
  endtask

  always @(posedge sys_clk) begin
    logic [KN-1:0] seen;
    logic          flip;
    int            t;
    edge_n++;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
    e_rep   = '0;
    if (!sys_rst) begin
      model_reset();
    end else begin
      seen = raw_q[raw_q.size()-2];
      raw_q.push_back(~key_in);
      void'(raw_q.pop_front());
      seen_q.push_back(seen);
      if (seen_q.size() > DEB) void'(seen_q.pop_front());
      for (int c = 0; c < KN; c++) begin
        flip = (seen_q.size() == DEB);
        foreach (seen_q[i]) if (seen_q[i][c] == m_status[c]) flip = 1'b0;
        if (flip) begin
          m_status[c] = ~m_status[c];
          if (m_status[c]) begin
            e_press[c]    = 1'b1;
            press_edge[c] = edge_n;
          end else begin
            e_rel[c] = 1'b1;
          end
        end else if (m_status[c]) begin
          t = edge_n - press_edge[c];
`ifdef KEY_LONGPRESS_EN
          if (t == LONG) e_long[c] = 1'b1;
          if (t > LONG && ((t - LONG) % REP) == 0) e_rep[c] = 1'b1;
`else
          if (t < 0) e_long[c] = 1'b1;
`endif
        end
      end
    end
    #1;
    check("status",  32'(key_status),  32'(m_status));
    check("press",   32'(key_press),   32'(e_press));
    check("release", 32'(key_release), 32'(e_rel));
    check("long",    32'(key_long),    32'(e_long));
    check("repeat",  32'(key_repeat),  32'(e_rep));
    check("any",     32'(key_any),     32'(|m_status));
  end

  // Driver tasks: inputs change on the falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic set_key(input int idx, input bit pressed);
    key_in[idx] = ~pressed;
  endtask

  initial begin
    model_reset();
    // Reset with all keys released (pins high) for 50 clocks.
    key_in  = '1;
    sys_rst = 1'b0;
    cycles(50);
    sys_rst = 1'b1;
    cycles(10);

    // Single press on key 0.
    set_key(0, 1'b1);
    cycles(10);

    // Key 1 glitch shorter than the debounce window.
    set_key(1, 1'b1);
    cycles(3);
    set_key(1, 1'b0);
    cycles(10);

    // Keys 2 and 3 together, press then release.
    set_key(2, 1'b1);
    set_key(3, 1'b1);
    cycles(10);
    set_key(2, 1'b0);
    set_key(3, 1'b0);
    cycles(40);

    // Key 0 has now been held well past the long-press point; release it.
    set_key(0, 1'b0);
    cycles(40);

    // Reset mid-debounce on key 0 while key 3 is already accepted.
    set_key(3, 1'b1);
    cycles(10);
    set_key(0, 1'b1);
    repeat (4) @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
    #1;
    check("rst_async_status", 32'(key_status), 32'(0));
    check("rst_async_press",  32'(key_press),  32'(0));
    check("rst_async_any",    32'(key_any),    32'(0));
    cycles(3);
    sys_rst = 1'b1;
    cycles(20);
    key_in = '1;
    cycles(20);

    // Random key activity with random hold lengths.
    for (int i = 0; i < 400; i++) begin
      key_in = KN'($urandom_range(0, (1 << KN) - 1));
      cycles($urandom_range(1, 10));
    end
    key_in = '0;
    cycles(60);
    key_in = '1;
    cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
